// File: rtl/multicycle_control_unit_pkg.sv
// Shared definitions for the multicycle control unit: opcodes, FSM states,
// RF write-back source codes, instruction classes and the select vector.
package multicycle_control_unit_pkg;

    // Opcode field values (IR[6:0]) understood by the core
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    // FSM states; the encoding is visible on the debug state port
    typedef enum logic [2:0] {
        ST_INIT   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_MEM    = 3'd4,
        ST_WB     = 3'd5,
        ST_TRAP   = 3'd6
    } state_e;

    // Register-file write-back source codes
    localparam logic [1:0] RF_DIN_MEM   = 2'd0;
    localparam logic [1:0] RF_DIN_ULA   = 2'd1;
    localparam logic [1:0] RF_DIN_PC4   = 2'd2;
    localparam logic [1:0] RF_DIN_PCIMM = 2'd3;

    // Instruction classes produced by the decoder
    typedef enum logic [3:0] {
        CLS_ILLEGAL = 4'd0,
        CLS_LD      = 4'd1,
        CLS_ADD     = 4'd2,
        CLS_SUB     = 4'd3,
        CLS_ADDI    = 4'd4,
        CLS_ST      = 4'd5,
        CLS_BEQ     = 4'd6,
        CLS_BNE     = 4'd7,
        CLS_AUIPC   = 4'd8,
        CLS_JAL     = 4'd9,
        CLS_JALR    = 4'd10
    } instr_class_e;

    // Datapath select vector held from EXEC through WB
    typedef struct packed {
        logic       sub;
        logic       din2Sel;
        logic [1:0] rfDinSel;
        logic       pcNextSel;
        logic       pcAdderSel;
    } sel_vec_t;

    localparam sel_vec_t SEL_NONE = '0;

    // Builds a select vector from its individual fields
    function automatic sel_vec_t mkSel(input logic s, input logic d,
                                       input logic [1:0] rf,
                                       input logic pn, input logic pa);
        sel_vec_t v;
        v.sub        = s;
        v.din2Sel    = d;
        v.rfDinSel   = rf;
        v.pcNextSel  = pn;
        v.pcAdderSel = pa;
        return v;
    endfunction

    // Classes that write a destination register in WB
    function automatic logic clsWritesRf(input instr_class_e c);
        return (c == CLS_LD)    || (c == CLS_ADD) || (c == CLS_SUB) ||
               (c == CLS_ADDI)  || (c == CLS_AUIPC) ||
               (c == CLS_JAL)   || (c == CLS_JALR);
    endfunction

    // Classes that need the extra MEM cycle
    function automatic logic clsUsesMem(input instr_class_e c);
        return (c == CLS_LD) || (c == CLS_ST);
    endfunction

    // Conditional branches whose PC adder select depends on the zero flag
    function automatic logic clsIsBranch(input instr_class_e c);
        return (c == CLS_BEQ) || (c == CLS_BNE);
    endfunction

endpackage

// File: rtl/multicycle_control_unit_instr_decoder.sv
// Combinational instruction decoder: classifies the IR fields and produces
// the datapath select vector plus an illegal-instruction flag.
module instr_decoder
    import multicycle_control_unit_pkg::*;
(
    input  logic [6:0]   i_opcode,
    input  logic [2:0]   i_funct3,
    input  logic         i_funct7_5,
    output instr_class_e o_class,
    output sel_vec_t     o_sel,
    output logic         o_illegal
);

    // Anything not explicitly recognised falls through as illegal
    always_comb begin
        o_class = CLS_ILLEGAL;
        o_sel   = SEL_NONE;
        case (i_opcode)
            OPC_LOAD: begin
                if (i_funct3 == 3'b011) begin
                    o_class = CLS_LD;
                    o_sel   = mkSel(1'b0, 1'b1, RF_DIN_MEM, 1'b0, 1'b0);
                end
            end
            OPC_STORE: begin
                if (i_funct3 == 3'b011) begin
                    o_class = CLS_ST;
                    o_sel   = mkSel(1'b0, 1'b1, RF_DIN_MEM, 1'b0, 1'b0);
                end
            end
            OPC_OP: begin
                if (i_funct3 == 3'b000) begin
                    if (i_funct7_5) begin
                        o_class = CLS_SUB;
                        o_sel   = mkSel(1'b1, 1'b0, RF_DIN_ULA, 1'b0, 1'b0);
                    end else begin
                        o_class = CLS_ADD;
                        o_sel   = mkSel(1'b0, 1'b0, RF_DIN_ULA, 1'b0, 1'b0);
                    end
                end
            end
            OPC_OPIMM: begin
                if ((i_funct3 == 3'b000) && !i_funct7_5) begin
                    o_class = CLS_ADDI;
                    o_sel   = mkSel(1'b0, 1'b1, RF_DIN_ULA, 1'b0, 1'b0);
                end
            end
            OPC_BRANCH: begin
                if (i_funct3 == 3'b000) begin
                    o_class = CLS_BEQ;
                    o_sel   = mkSel(1'b1, 1'b0, RF_DIN_MEM, 1'b0, 1'b0);
                end else if (i_funct3 == 3'b001) begin
                    o_class = CLS_BNE;
                    o_sel   = mkSel(1'b1, 1'b0, RF_DIN_MEM, 1'b0, 1'b0);
                end
            end
            OPC_AUIPC: begin
                o_class = CLS_AUIPC;
                o_sel   = mkSel(1'b0, 1'b0, RF_DIN_PCIMM, 1'b0, 1'b1);
            end
            OPC_JAL: begin
                o_class = CLS_JAL;
                o_sel   = mkSel(1'b0, 1'b0, RF_DIN_PC4, 1'b1, 1'b1);
            end
            OPC_JALR: begin
                if (i_funct3 == 3'b000) begin
                    o_class = CLS_JALR;
                    o_sel   = mkSel(1'b0, 1'b1, RF_DIN_PC4, 1'b1, 1'b0);
                end
            end
            default: begin
                o_class = CLS_ILLEGAL;
                o_sel   = SEL_NONE;
            end
        endcase
    end

    assign o_illegal = (o_class == CLS_ILLEGAL);

endmodule

// File: rtl/multicycle_control_unit.sv
// Multicycle control FSM for the load-store datapath. Sequences
// INIT -> FETCH -> DECODE -> EXEC -> [MEM] -> WB and traps on illegal code.
module multicycle_control_unit
    import multicycle_control_unit_pkg::*;
#(
    parameter int INIT_CYCLES = 1
) (
    input  logic       CLK,
    input  logic       reset,
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic       funct7_5,
    input  logic       zero,
    output logic       sub,
    output logic       ULA_din2_sel,
    output logic [1:0] RF_din_sel,
    output logic       WE_RF,
    output logic       WE_MEM,
    output logic       load_pc,
    output logic       reset_pc,
    output logic       pc_next_sel,
    output logic       pc_adder_sel,
    output logic       reset_ir,
    output logic       load_ir,
    output logic       instr_done,
    output logic       halted,
    output logic [2:0] state
);

    localparam logic [3:0] INIT_LAST = 4'(INIT_CYCLES - 1);

    state_e       r_state;
    state_e       w_nextState;
    logic [3:0]   r_initCnt;
    instr_class_e r_cls;
    sel_vec_t     r_sel;
    instr_class_e w_cls;
    sel_vec_t     w_sel;
    logic         w_illegal;
    logic         w_branchTaken;

    instr_decoder u_decoder (
        .i_opcode   (opcode),
        .i_funct3   (funct3),
        .i_funct7_5 (funct7_5),
        .o_class    (w_cls),
        .o_sel      (w_sel),
        .o_illegal  (w_illegal)
    );

    // Branch outcome follows the live zero flag; IR is stable so the
    // registered class stands in for funct3
    assign w_branchTaken = ((r_cls == CLS_BEQ) &&  zero) ||
                           ((r_cls == CLS_BNE) && !zero);

    assign state = 3'(r_state);

    // State register and INIT hold counter; reset wins over everything
    always_ff @(posedge CLK) begin
        if (reset) begin
            r_state   <= ST_INIT;
            r_initCnt <= '0;
        end else begin
            r_state   <= w_nextState;
            r_initCnt <= (r_state == ST_INIT) ? r_initCnt + 4'd1 : 4'd0;
        end
    end

    // Capture the decoded class and selects as DECODE completes
    always_ff @(posedge CLK) begin
        if (reset) begin
            r_cls <= CLS_ILLEGAL;
            r_sel <= SEL_NONE;
        end else if (r_state == ST_DECODE) begin
            r_cls <= w_cls;
            r_sel <= w_sel;
        end
    end

    // Next-state and per-state control outputs
    always_comb begin
        w_nextState  = r_state;
        sub          = 1'b0;
        ULA_din2_sel = 1'b0;
        RF_din_sel   = RF_DIN_MEM;
        WE_RF        = 1'b0;
        WE_MEM       = 1'b0;
        load_pc      = 1'b0;
        reset_pc     = 1'b0;
        pc_next_sel  = 1'b0;
        pc_adder_sel = 1'b0;
        reset_ir     = 1'b0;
        load_ir      = 1'b0;
        instr_done   = 1'b0;
        halted       = 1'b0;

        if ((r_state == ST_EXEC) || (r_state == ST_MEM) || (r_state == ST_WB)) begin
            sub          = r_sel.sub;
            ULA_din2_sel = r_sel.din2Sel;
            RF_din_sel   = r_sel.rfDinSel;
            pc_next_sel  = r_sel.pcNextSel;
            pc_adder_sel = clsIsBranch(r_cls) ? w_branchTaken : r_sel.pcAdderSel;
        end

        case (r_state)
            ST_INIT: begin
                reset_pc = 1'b1;
                reset_ir = 1'b1;
                if (r_initCnt == INIT_LAST) begin
                    w_nextState = ST_FETCH;
                end
            end
            ST_FETCH: begin
                load_ir     = 1'b1;
                w_nextState = ST_DECODE;
            end
            ST_DECODE: begin
                w_nextState = w_illegal ? ST_TRAP : ST_EXEC;
            end
            ST_EXEC: begin
                w_nextState = clsUsesMem(r_cls) ? ST_MEM : ST_WB;
            end
            ST_MEM: begin
                WE_MEM      = (r_cls == CLS_ST);
                w_nextState = ST_WB;
            end
            ST_WB: begin
                WE_RF      = clsWritesRf(r_cls);
                load_pc    = 1'b1;
                instr_done = 1'b1;
                if (r_cls == CLS_AUIPC) begin
                    pc_adder_sel = 1'b0;
                end
                w_nextState = ST_FETCH;
            end
            ST_TRAP: begin
                halted       = 1'b1;
                sub          = 1'b0;
                ULA_din2_sel = 1'b0;
                RF_din_sel   = RF_DIN_MEM;
                pc_next_sel  = 1'b0;
                pc_adder_sel = 1'b0;
                w_nextState  = ST_TRAP;
            end
            default: begin
                w_nextState = ST_INIT;
            end
        endcase
    end

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Testbench for multicycle_control_unit: directed sequences plus random
// instructions, each cycle compared against a phase-based reference model.
module tb_multicycle_control_unit;

    localparam int TB_INIT = 3;

    // Phase numbers equal the architectural state codes
    localparam int P_INIT = 0, P_FETCH = 1, P_DECODE = 2, P_EXEC = 3,
                   P_MEM = 4, P_WB = 5, P_TRAP = 6;

    localparam int K_ILL = 0, K_LD = 1, K_ADD = 2, K_SUB = 3, K_ADDI = 4,
                   K_ST = 5, K_BEQ = 6, K_BNE = 7, K_AUIPC = 8, K_JAL = 9,
                   K_JALR = 10;

    logic       CLK = 1'b0;
    logic       reset;
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       funct7_5;
    logic       zero;
    logic       sub, ULA_din2_sel, WE_RF, WE_MEM, load_pc, reset_pc;
    logic       pc_next_sel, pc_adder_sel, reset_ir, load_ir, instr_done, halted;
    logic [1:0] RF_din_sel;
    logic [2:0] state;
    logic [13:0] obsOut;

    int vectorCount = 0;
    int missCount   = 0;
    int forceZero   = -1;
    logic rstDrive  = 1'b1;

    always #5 CLK = ~CLK;

    multicycle_control_unit #(.INIT_CYCLES(TB_INIT)) dut (
        .CLK          (CLK),
        .reset        (reset),
        .opcode       (opcode),
        .funct3       (funct3),
        .funct7_5     (funct7_5),
        .zero         (zero),
        .sub          (sub),
        .ULA_din2_sel (ULA_din2_sel),
        .RF_din_sel   (RF_din_sel),
        .WE_RF        (WE_RF),
        .WE_MEM       (WE_MEM),
        .load_pc      (load_pc),
        .reset_pc     (reset_pc),
        .pc_next_sel  (pc_next_sel),
        .pc_adder_sel (pc_adder_sel),
        .reset_ir     (reset_ir),
        .load_ir      (load_ir),
        .instr_done   (instr_done),
        .halted       (halted),
        .state        (state)
    );

    assign obsOut = {halted, instr_done, load_ir, reset_ir, reset_pc, load_pc,
                     WE_MEM, WE_RF, pc_adder_sel, pc_next_sel, RF_din_sel,
                     ULA_din2_sel, sub};

    // Single comparison point; every check is counted here
    task automatic checkOutput(input string tag, input logic [31:0] obs,
                               input logic [31:0] exp);
        vectorCount++;
        if (obs !== exp) begin
            missCount++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Instruction kind straight from the opcode/funct rules of the ISA subset
    function automatic int refKind(input logic [6:0] op, input logic [2:0] f3, input logic f7);
        int k;
        k = K_ILL;
        case (op)
            7'b0000011: k = (f3 == 3'b011) ? K_LD : K_ILL;
            7'b0100011: k = (f3 == 3'b011) ? K_ST : K_ILL;
            7'b0110011: k = (f3 != 3'b000) ? K_ILL : (f7 ? K_SUB : K_ADD);
            7'b0010011: k = (f3 == 3'b000 && !f7) ? K_ADDI : K_ILL;
            7'b0010111: k = K_AUIPC;
            7'b1101111: k = K_JAL;
            7'b1100111: k = (f3 == 3'b000) ? K_JALR : K_ILL;
            7'b1100011: k = (f3 == 3'b000) ? K_BEQ : ((f3 == 3'b001) ? K_BNE : K_ILL);
            default:    k = K_ILL;
        endcase
        return k;
    endfunction

    // {sub, din2, RF_din[1:0], pc_next, pc_adder} table per instruction kind
    function automatic logic [5:0] selTuple(input int k);
        case (k)
            K_LD:    return {1'b0, 1'b1, 2'd0, 1'b0, 1'b0};
            K_ADD:   return {1'b0, 1'b0, 2'd1, 1'b0, 1'b0};
            K_SUB:   return {1'b1, 1'b0, 2'd1, 1'b0, 1'b0};
            K_ADDI:  return {1'b0, 1'b1, 2'd1, 1'b0, 1'b0};
            K_ST:    return {1'b0, 1'b1, 2'd0, 1'b0, 1'b0};
            K_BEQ:   return {1'b1, 1'b0, 2'd0, 1'b0, 1'b0};
            K_BNE:   return {1'b1, 1'b0, 2'd0, 1'b0, 1'b0};
            K_AUIPC: return {1'b0, 1'b0, 2'd3, 1'b0, 1'b1};
            K_JAL:   return {1'b0, 1'b0, 2'd2, 1'b1, 1'b1};
            K_JALR:  return {1'b0, 1'b1, 2'd2, 1'b1, 1'b0};
            default: return 6'd0;
        endcase
    endfunction

    // Expected output word for a phase of an instruction of kind k
    function automatic logic [13:0] modelOutputs(input int phase, input int k, input logic z);
        logic [13:0] e;
        logic [5:0]  s;
        logic        taken;
        e = '0;
        s = selTuple(k);
        taken = (k == K_BEQ && z) || (k == K_BNE && !z);
        if (phase == P_EXEC || phase == P_MEM || phase == P_WB) begin
            e[0]   = s[5];
            e[1]   = s[4];
            e[3:2] = s[3:2];
            e[4]   = s[1];
            e[5]   = (k == K_BEQ || k == K_BNE) ? taken : s[0];
        end
        case (phase)
            P_INIT:  begin e[9] = 1'b1; e[10] = 1'b1; end
            P_FETCH: e[11] = 1'b1;
            P_MEM:   e[7] = (k == K_ST);
            P_WB: begin
                if (k == K_AUIPC) e[5] = 1'b0;
                e[6]  = !(k == K_ST || k == K_BEQ || k == K_BNE);
                e[8]  = 1'b1;
                e[12] = 1'b1;
            end
            P_TRAP:  e[13] = 1'b1;
            default: ;
        endcase
        return e;
    endfunction

    // One clock: drive at negedge, compare state and outputs shortly after
    task automatic stepCheck(input int phase, input int k, input string tag);
        logic [13:0] expOut;
        @(negedge CLK);
        reset = rstDrive;
        if (forceZero < 0) zero = 1'($urandom_range(0, 1));
        else               zero = 1'(forceZero);
        #1;
        expOut = modelOutputs(phase, k, zero);
        checkOutput({tag, "/state"}, 32'(state), 32'(phase));
        checkOutput({tag, "/outs"}, 32'(obsOut), 32'(expOut));
    endtask

    // Hold reset for nHold edges, then expect TB_INIT cycles of INIT
    task automatic applyReset(input int nHold);
        @(negedge CLK);
        rstDrive = 1'b1;
        reset    = 1'b1;
        for (int i = 1; i < nHold; i++) stepCheck(P_INIT, K_ILL, "rst_hold");
        rstDrive = 1'b0;
        for (int i = 0; i < TB_INIT; i++) stepCheck(P_INIT, K_ILL, "init");
    endtask

    // Run one instruction through its phases, trapping for trapCycles if illegal
    task automatic applyStimulus(input logic [6:0] op, input logic [2:0] f3,
                                 input logic f7, input int trapCycles, input string tag);
        int k;
        k = refKind(op, f3, f7);
        opcode   = op;
        funct3   = f3;
        funct7_5 = f7;
        stepCheck(P_FETCH, k, tag);
        stepCheck(P_DECODE, k, tag);
        if (k == K_ILL) begin
            for (int i = 0; i < trapCycles; i++) stepCheck(P_TRAP, k, tag);
        end else begin
            stepCheck(P_EXEC, k, tag);
            if (k == K_LD || k == K_ST) stepCheck(P_MEM, k, tag);
            stepCheck(P_WB, k, tag);
        end
    endtask

    // Random IR fields that land in the requested kind
    task automatic genFields(input int k, output logic [6:0] op,
                             output logic [2:0] f3, output logic f7);
        int cat;
        f3 = 3'($urandom);
        f7 = 1'($urandom);
        case (k)
            K_LD:    begin op = 7'b0000011; f3 = 3'b011; end
            K_ST:    begin op = 7'b0100011; f3 = 3'b011; end
            K_ADD:   begin op = 7'b0110011; f3 = 3'b000; f7 = 1'b0; end
            K_SUB:   begin op = 7'b0110011; f3 = 3'b000; f7 = 1'b1; end
            K_ADDI:  begin op = 7'b0010011; f3 = 3'b000; f7 = 1'b0; end
            K_BEQ:   begin op = 7'b1100011; f3 = 3'b000; end
            K_BNE:   begin op = 7'b1100011; f3 = 3'b001; end
            K_AUIPC: op = 7'b0010111;
            K_JAL:   op = 7'b1101111;
            K_JALR:  begin op = 7'b1100111; f3 = 3'b000; end
            default: begin
                cat = $urandom_range(0, 5);
                case (cat)
                    0: begin
                        do op = 7'($urandom);
                        while (op inside {7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011,
                                          7'b0010111, 7'b1101111, 7'b1100111, 7'b1100011});
                    end
                    1: begin op = ($urandom_range(0, 1) != 0) ? 7'b0110011 : 7'b0010011;
                             f3 = 3'($urandom_range(1, 7)); end
                    2: begin op = 7'b0010011; f3 = 3'b000; f7 = 1'b1; end
                    3: begin op = ($urandom_range(0, 1) != 0) ? 7'b0000011 : 7'b0100011;
                             do f3 = 3'($urandom); while (f3 == 3'b011); end
                    4: begin op = 7'b1100011; f3 = 3'($urandom_range(2, 7)); end
                    default: begin op = 7'b1100111; f3 = 3'($urandom_range(1, 7)); end
                endcase
            end
        endcase
    endtask

    // Store interrupted by reset while WE_MEM is high
    task automatic resetDuringStore();
        int k;
        k = K_ST;
        opcode = 7'b0100011; funct3 = 3'b011; funct7_5 = 1'b0;
        stepCheck(P_FETCH, k, "st_rst");
        stepCheck(P_DECODE, k, "st_rst");
        stepCheck(P_EXEC, k, "st_rst");
        rstDrive = 1'b1;
        stepCheck(P_MEM, k, "st_rst_mem");
        rstDrive = 1'b0;
        for (int i = 0; i < TB_INIT; i++) stepCheck(P_INIT, K_ILL, "st_rst_init");
    endtask

    // Watchdog so a stuck run still ends with a report
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed sequences followed by random instruction mix
    initial begin
        logic [6:0] op;
        logic [2:0] f3;
        logic       f7;
        int         k;
        reset = 1'b1; opcode = '0; funct3 = '0; funct7_5 = 1'b0; zero = 1'b0;
        applyReset(2);

        applyStimulus(7'b0110011, 3'b000, 1'b0, 0, "add");
        applyStimulus(7'b0000011, 3'b011, 1'b0, 0, "ld");
        applyStimulus(7'b0100011, 3'b011, 1'b0, 0, "st");
        applyStimulus(7'b0110011, 3'b000, 1'b1, 0, "sub");

        forceZero = 1;
        applyStimulus(7'b1100011, 3'b000, 1'b0, 0, "beq_z1");
        forceZero = 0;
        applyStimulus(7'b1100011, 3'b000, 1'b0, 0, "beq_z0");
        applyStimulus(7'b1100011, 3'b001, 1'b0, 0, "bne_z0");
        forceZero = -1;

        applyStimulus(7'b0010111, 3'b101, 1'b1, 0, "auipc");
        applyStimulus(7'b1101111, 3'b010, 1'b0, 0, "jal");
        applyStimulus(7'b1100111, 3'b000, 1'b0, 0, "jalr");

        applyStimulus(7'b0000000, 3'b000, 1'b0, 20, "ill_opc");
        applyReset(1);
        applyStimulus(7'b0010011, 3'b001, 1'b0, 20, "ill_opimm");
        applyReset(1);

        resetDuringStore();

        for (int n = 0; n < 60; n++) begin
            k = $urandom_range(0, 10);
            genFields(k, op, f3, f7);
            applyStimulus(op, f3, f7, 5, "rand");
            if (refKind(op, f3, f7) == K_ILL) applyReset($urandom_range(1, 3));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
        $finish;
    end

endmodule
